kl8e_tty: RTL and testbench

Console teletype controller, PDP-8 KL8E style. Decodes CPU IOT instructions for the keyboard and printer devices, holds the keyboard buffer, both device flags and interrupt enable. Acts as the initiator on the `uart` req/ack load/unload handshakes, which the UART answers on its own `tx_clk`/`rx_clk`. Sits between the CPU IOT bus and the `uart` instance in the top level.

---
 rtl/kl8e_tty_if.sv | 34 +++
 rtl/kl8e_tty.sv | 142 ++++++++++++++
 tb/tb_kl8e_tty.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kl8e_tty_if.sv
// Bundles the CPU IOT bus and the UART load/unload handshakes for the KL8E console controller.
// The controller takes the slave modport; the CPU/UART environment takes the master modport.
interface kl8e_tty_if;
    logic       iot;
    logic [5:0] io_device;
    logic [2:0] io_op;
    logic [7:0] ac_in;
    logic [7:0] io_data_out;
    logic       io_skip;
    logic       io_clear_ac;
    logic       interrupt;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       tx_empty;
    logic       rx_req;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       rx_empty;
    logic       rx_overrun;
    logic       tx_overrun;

    modport slave (
        input  iot, io_device, io_op, ac_in, tx_ack, tx_empty, rx_data, rx_ack, rx_empty,
        output io_data_out, io_skip, io_clear_ac, interrupt, tx_req, tx_data, rx_req,
               rx_overrun, tx_overrun
    );

    modport master (
        output iot, io_device, io_op, ac_in, tx_ack, tx_empty, rx_data, rx_ack, rx_empty,
        input  io_data_out, io_skip, io_clear_ac, interrupt, tx_req, tx_data, rx_req,
               rx_overrun, tx_overrun
    );
endinterface

// File: rtl/kl8e_tty.sv
// PDP-8 KL8E console teletype controller: keyboard/printer IOT decode, flags, interrupt enable,
// and the initiator side of the UART req/ack load and unload handshakes.
module kl8e_tty #(
    parameter logic [5:0] KBD_DEV = 6'o03,
    parameter logic [5:0] TTY_DEV = 6'o04
) (
    input logic        clk,
    input logic        reset,
    kl8e_tty_if.slave  bus
);
    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_REL  = 2'd2;
    localparam logic [1:0] TX_BUSY = 2'd3;

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_REQ  = 2'd1;
    localparam logic [1:0] RX_REL  = 2'd2;
    localparam logic [1:0] RX_DONE = 2'd3;

    logic [1:0] tx_state_q, tx_state_d;
    logic [1:0] rx_state_q, rx_state_d;
    logic [1:0] tx_ack_sync_q, tx_ack_sync_d;
    logic [1:0] tx_empty_sync_q, tx_empty_sync_d;
    logic [1:0] rx_ack_sync_q, rx_ack_sync_d;
    logic [1:0] rx_empty_sync_q, rx_empty_sync_d;
    logic [7:0] kbd_buf_q, kbd_buf_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       kbd_flag_q, kbd_flag_d;
    logic       tty_flag_q, tty_flag_d;
    logic       ie_q, ie_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_overrun_q, tx_overrun_d;

    logic tx_ack_s, tx_empty_s, rx_ack_s, rx_empty_s;
    logic kbd_sel, tty_sel, kie, print;
    logic tty_set, kbd_set;

    assign tx_ack_s   = tx_ack_sync_q[1];
    assign tx_empty_s = tx_empty_sync_q[1];
    assign rx_ack_s   = rx_ack_sync_q[1];
    assign rx_empty_s = rx_empty_sync_q[1];

    assign kbd_sel = bus.iot && (bus.io_device == KBD_DEV);
    assign tty_sel = bus.iot && (bus.io_device == TTY_DEV);
    assign kie     = kbd_sel && (bus.io_op == 3'd5);
    assign print   = tty_sel && bus.io_op[2];

    // KIE reuses the skip and read bits, so it suppresses both.
    always_comb begin
        bus.io_skip     = (kbd_sel && !kie && bus.io_op[0] && kbd_flag_q) ||
                          (tty_sel && bus.io_op[0] && tty_flag_q);
        bus.io_clear_ac = kbd_sel && bus.io_op[1];
        bus.io_data_out = (kbd_sel && !kie && bus.io_op[2]) ? kbd_buf_q : 8'h00;
        bus.interrupt   = ie_q && (kbd_flag_q || tty_flag_q);
        bus.tx_req      = (tx_state_q == TX_REQ);
        bus.rx_req      = (rx_state_q == RX_REQ);
        bus.tx_data     = tx_hold_q;
        bus.rx_overrun  = rx_overrun_q;
        bus.tx_overrun  = tx_overrun_q;
    end

    always_comb begin
        tx_ack_sync_d   = {tx_ack_sync_q[0], bus.tx_ack};
        tx_empty_sync_d = {tx_empty_sync_q[0], bus.tx_empty};
        rx_ack_sync_d   = {rx_ack_sync_q[0], bus.rx_ack};
        rx_empty_sync_d = {rx_empty_sync_q[0], bus.rx_empty};

        tx_state_d   = tx_state_q;
        tx_hold_d    = tx_hold_q;
        tx_overrun_d = tx_overrun_q;
        tty_set      = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: if (print) begin
                tx_hold_d  = bus.ac_in;
                tx_state_d = TX_REQ;
            end
            TX_REQ:  if (tx_ack_s) tx_state_d = TX_REL;
            TX_REL:  if (!tx_ack_s) tx_state_d = TX_BUSY;
            TX_BUSY: if (tx_empty_s) begin
                tty_set    = 1'b1;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (print && (tx_state_q != TX_IDLE)) tx_overrun_d = 1'b1;

        rx_state_d   = rx_state_q;
        kbd_buf_d    = kbd_buf_q;
        rx_overrun_d = rx_overrun_q;
        kbd_set      = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: if (!rx_empty_s) rx_state_d = RX_REQ;
            RX_REQ:  if (rx_ack_s) rx_state_d = RX_REL;
            RX_REL:  if (!rx_ack_s) rx_state_d = RX_DONE;
            RX_DONE: begin
                kbd_buf_d = bus.rx_data;
                kbd_set   = 1'b1;
                if (kbd_flag_q) rx_overrun_d = 1'b1;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // A flag set by an FSM beats a clear from an IOT in the same cycle.
        tty_flag_d = tty_set ? 1'b1 : ((tty_sel && bus.io_op[1]) ? 1'b0 : tty_flag_q);
        kbd_flag_d = kbd_set ? 1'b1 : ((kbd_sel && bus.io_op[1]) ? 1'b0 : kbd_flag_q);
        ie_d       = kie ? bus.ac_in[0] : ie_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q      <= TX_IDLE;
            rx_state_q      <= RX_IDLE;
            tx_ack_sync_q   <= 2'b00;
            tx_empty_sync_q <= 2'b11;
            rx_ack_sync_q   <= 2'b00;
            rx_empty_sync_q <= 2'b11;
            kbd_buf_q       <= 8'h00;
            tx_hold_q       <= 8'h00;
            kbd_flag_q      <= 1'b0;
            tty_flag_q      <= 1'b0;
            ie_q            <= 1'b1;
            rx_overrun_q    <= 1'b0;
            tx_overrun_q    <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            rx_state_q      <= rx_state_d;
            tx_ack_sync_q   <= tx_ack_sync_d;
            tx_empty_sync_q <= tx_empty_sync_d;
            rx_ack_sync_q   <= rx_ack_sync_d;
            rx_empty_sync_q <= rx_empty_sync_d;
            kbd_buf_q       <= kbd_buf_d;
            tx_hold_q       <= tx_hold_d;
            kbd_flag_q      <= kbd_flag_d;
            tty_flag_q      <= tty_flag_d;
            ie_q            <= ie_d;
            rx_overrun_q    <= rx_overrun_d;
            tx_overrun_q    <= tx_overrun_d;
        end
    end
endmodule

// File: tb/tb_kl8e_tty.sv
// Scoreboard bench for kl8e_tty: a transaction-level console model predicts IOT responses and
// printed characters; monitors compare them as the DUT presents them.
module tb_kl8e_tty;
    localparam logic [5:0] KBD = 6'o03;
    localparam logic [5:0] TTY = 6'o04;

    logic clk = 1'b0;
    logic reset;
    kl8e_tty_if bus();

    kl8e_tty #(.KBD_DEV(KBD), .TTY_DEV(TTY)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       skip;
        logic       clr;
        logic [7:0] data;
    } iot_rsp_t;

    iot_rsp_t   iot_exp[$];
    logic [7:0] tx_exp[$];

    // Console model state
    logic [7:0] m_kbd_buf;
    bit m_kbd_flag, m_tty_flag, m_ie, m_rx_ovr, m_tx_ovr, m_tx_busy;

    bit tx_stall = 1'b0;
    bit tx_in_busy = 1'b0;
    int tx_busy_len = 8;
    int tx_done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_kbd_buf = 8'h00; m_kbd_flag = 0; m_tty_flag = 0; m_ie = 1;
        m_rx_ovr = 0; m_tx_ovr = 0; m_tx_busy = 0;
    endtask

    // IOT response monitor
    always @(negedge clk) begin
        if (bus.iot === 1'b1 && reset === 1'b0) begin
            if (iot_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL iot_unexpected: actual strobe required none");
            end else begin
                iot_rsp_t r;
                r = iot_exp.pop_front();
                chk("io_skip", {31'd0, bus.io_skip}, {31'd0, r.skip});
                chk("io_clear_ac", {31'd0, bus.io_clear_ac}, {31'd0, r.clr});
                chk("io_data_out", {24'd0, bus.io_data_out}, {24'd0, r.data});
            end
        end
    end

    // UART transmitter: answers the load handshake and checks the loaded character
    initial begin
        bus.tx_ack = 1'b0;
        bus.tx_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_req === 1'b1 && !tx_stall && reset === 1'b0) begin
                int n;
                bus.tx_empty = 1'b0;
                @(negedge clk);
                bus.tx_ack = 1'b1;
                if (tx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected_load: actual char %0h required no load", bus.tx_data);
                end else begin
                    chk("tx_data_loaded", {24'd0, bus.tx_data}, {24'd0, tx_exp.pop_front()});
                end
                n = 0;
                while (bus.tx_req === 1'b1 && n < 40) begin @(negedge clk); n++; end
                if (n >= 40) begin
                    checks++; errors++;
                    $display("FAIL tx_req_release: actual 1 required 0");
                end
                bus.tx_ack = 1'b0;
                repeat (6) @(negedge clk);
                tx_in_busy = 1'b1;
                repeat (tx_busy_len) @(negedge clk);
                bus.tx_empty = 1'b1;
                tx_in_busy = 1'b0;
                repeat (6) @(negedge clk);
                m_tty_flag = 1;
                m_tx_busy = 0;
                tx_done_cnt++;
            end
        end
    end

    task automatic iot_cmd(input logic [5:0] dev, input logic [2:0] op, input logic [7:0] ac);
        iot_rsp_t r;
        r.skip = 1'b0; r.clr = 1'b0; r.data = 8'h00;
        if (dev == KBD) begin
            if (op == 3'd5) m_ie = ac[0];
            else begin
                r.skip = op[0] & m_kbd_flag;
                r.clr  = op[1];
                r.data = op[2] ? m_kbd_buf : 8'h00;
                if (op[1]) m_kbd_flag = 0;
            end
        end else if (dev == TTY) begin
            r.skip = op[0] & m_tty_flag;
            if (op[1]) m_tty_flag = 0;
            if (op[2]) begin
                if (m_tx_busy) m_tx_ovr = 1;
                else begin m_tx_busy = 1; tx_exp.push_back(ac); end
            end
        end
        @(posedge clk); #1;
        bus.iot = 1'b1; bus.io_device = dev; bus.io_op = op; bus.ac_in = ac;
        iot_exp.push_back(r);
        @(posedge clk); #1;
        bus.iot = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] c);
        int n;
        bus.rx_data = c;
        bus.rx_empty = 1'b0;
        n = 0;
        while (bus.rx_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin checks++; errors++; $display("FAIL rx_req_rise: actual 0 required 1"); end
        bus.rx_empty = 1'b1;
        bus.rx_ack = 1'b1;
        n = 0;
        while (bus.rx_req === 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin checks++; errors++; $display("FAIL rx_req_release: actual 1 required 0"); end
        bus.rx_ack = 1'b0;
        repeat (6) @(negedge clk);
        if (m_kbd_flag) m_rx_ovr = 1;
        m_kbd_buf = c;
        m_kbd_flag = 1;
    endtask

    task automatic wait_tx_done(input int target);
        int n = 0;
        while (tx_done_cnt < target && n < 300) begin @(negedge clk); n++; end
        if (tx_done_cnt < target) begin
            checks++; errors++;
            $display("FAIL tx_complete: actual %0d completions required %0d", tx_done_cnt, target);
        end
    endtask

    task automatic check_state();
        @(negedge clk);
        chk("interrupt", {31'd0, bus.interrupt}, {31'd0, m_ie & (m_kbd_flag | m_tty_flag)});
        chk("rx_overrun", {31'd0, bus.rx_overrun}, {31'd0, m_rx_ovr});
        chk("tx_overrun", {31'd0, bus.tx_overrun}, {31'd0, m_tx_ovr});
    endtask

    task automatic check_reset_outputs();
        chk("rst_tx_req", {31'd0, bus.tx_req}, 0);
        chk("rst_rx_req", {31'd0, bus.rx_req}, 0);
        chk("rst_interrupt", {31'd0, bus.interrupt}, 0);
        chk("rst_rx_overrun", {31'd0, bus.rx_overrun}, 0);
        chk("rst_tx_overrun", {31'd0, bus.tx_overrun}, 0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 0);
        chk("rst_io_skip", {31'd0, bus.io_skip}, 0);
        chk("rst_io_clear_ac", {31'd0, bus.io_clear_ac}, 0);
        chk("rst_io_data_out", {24'd0, bus.io_data_out}, 0);
    endtask

    initial begin
        int cnt, n;
        reset = 1'b1;
        bus.iot = 1'b0; bus.io_device = 6'o00; bus.io_op = 3'd0; bus.ac_in = 8'h00;
        bus.rx_data = 8'h00; bus.rx_ack = 1'b0; bus.rx_empty = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;

        iot_cmd(KBD, 3'd1, 8'h00);
        iot_cmd(TTY, 3'd1, 8'h00);

        // TLS 'A'
        tx_busy_len = 8;
        cnt = tx_done_cnt;
        iot_cmd(TTY, 3'd6, 8'h41);
        @(negedge clk);
        chk("tls_tx_req", {31'd0, bus.tx_req}, 1);
        chk("tls_tx_data", {24'd0, bus.tx_data}, 32'h41);
        wait_tx_done(cnt + 1);
        iot_cmd(TTY, 3'd1, 8'h00);
        iot_cmd(TTY, 3'd2, 8'h00);
        iot_cmd(TTY, 3'd1, 8'h00);
        check_state();

        // Keyboard receive and read
        rx_send(8'h5A);
        iot_cmd(KBD, 3'd1, 8'h00);
        iot_cmd(KBD, 3'd6, 8'h00);
        iot_cmd(KBD, 3'd1, 8'h00);
        check_state();

        // Two characters without KRB
        rx_send(8'h31);
        rx_send(8'h32);
        check_state();
        iot_cmd(KBD, 3'd6, 8'h00);

        // Print while busy
        tx_busy_len = 20;
        cnt = tx_done_cnt;
        iot_cmd(TTY, 3'd6, 8'h55);
        n = 0;
        while (!tx_in_busy && n < 100) begin @(negedge clk); n++; end
        if (!tx_in_busy) begin checks++; errors++; $display("FAIL tx_busy_phase: actual 0 required 1"); end
        iot_cmd(TTY, 3'd6, 8'h66);
        @(negedge clk);
        chk("ovr_tx_data", {24'd0, bus.tx_data}, 32'h55);
        chk("ovr_tx_req", {31'd0, bus.tx_req}, 0);
        check_state();
        wait_tx_done(cnt + 1);
        repeat (10) @(negedge clk);
        chk("ovr_no_second_req", {31'd0, bus.tx_req}, 0);

        // Interrupt enable with both flags set
        rx_send(8'h77);
        iot_cmd(KBD, 3'd5, 8'hFE);
        check_state();
        chk("kie0_interrupt", {31'd0, bus.interrupt}, 0);
        iot_cmd(KBD, 3'd5, 8'h01);
        check_state();
        chk("kie1_interrupt", {31'd0, bus.interrupt}, 1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: rx_send(8'($urandom));
                1: iot_cmd(KBD, 3'($urandom_range(0, 7)), 8'($urandom));
                2: iot_cmd(TTY, 3'($urandom_range(0, 3)), 8'($urandom));
                3: begin
                    tx_busy_len = $urandom_range(3, 10);
                    cnt = tx_done_cnt;
                    iot_cmd(TTY, 3'($urandom_range(4, 7)), 8'($urandom));
                    wait_tx_done(cnt + 1);
                end
                4: iot_cmd(6'($urandom_range(5, 63)), 3'($urandom_range(0, 7)), 8'($urandom));
                default: iot_cmd(KBD, 3'd5, 8'($urandom));
            endcase
            check_state();
        end

        // Reset in mid-handshake: TX held in TX_REQ, RX held in RX_REL
        tx_stall = 1'b1;
        iot_cmd(TTY, 3'd6, 8'h99);
        bus.rx_data = 8'hA5;
        bus.rx_empty = 1'b0;
        n = 0;
        while (bus.rx_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        bus.rx_empty = 1'b1;
        bus.rx_ack = 1'b1;
        n = 0;
        while (bus.rx_req === 1'b1 && n < 40) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("pre_reset_tx_req", {31'd0, bus.tx_req}, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        model_reset();
        tx_exp.delete();
        bus.rx_ack = 1'b0;
        tx_stall = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        iot_cmd(KBD, 3'd1, 8'h00);
        tx_busy_len = 5;
        cnt = tx_done_cnt;
        iot_cmd(TTY, 3'd6, 8'h42);
        wait_tx_done(cnt + 1);
        iot_cmd(TTY, 3'd1, 8'h00);
        check_state();

        repeat (4) @(negedge clk);
        chk("iot_exp_left", iot_exp.size(), 0);
        chk("tx_exp_left", tx_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
